// File: rtl/flash_array_ctrl.sv
// flash_array_ctrl: sequences read/program/erase phases on the 8x8 NAND array
// and returns the captured/echoed byte on a valid/ready response channel.
module flash_array_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PRE   = 2,
  parameter int unsigned T_SENSE = 3,
  parameter int unsigned T_PROG  = 8,
  parameter int unsigned T_ERASE = 16,
  parameter int unsigned T_DIS   = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic [1:0] SSL,
  output logic [1:0] GSL,
  output logic [3:0] WL0,
  output logic [3:0] WL1,
  output logic       SL,
  output logic       PSUB,
  output logic       sen1,
  output logic       sen2,
  output logic [3:0] out_en,
  output logic [7:0] bl_out,
  output logic       bl_oe,
  input  logic [7:0] sa_out
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_PROG = 2'b01;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PRE,
    ST_SENSE,
    ST_CAPTURE,
    ST_PROGRAM,
    ST_ERASE,
    ST_DISCHARGE,
    ST_DONE
  } state_t;

  // All array-facing control lines, registered together.
  typedef struct packed {
    logic [1:0] ssl;
    logic [1:0] gsl;
    logic [3:0] wl0;
    logic [3:0] wl1;
    logic       sl;
    logic       psub;
    logic       sen1;
    logic       sen2;
    logic [3:0] out_en;
    logic [7:0] bl_out;
    logic       bl_oe;
  } lines_t;

  state_t           state_q;
  state_t           succ;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [2:0]       addr_q;
  logic [7:0]       wdata_q;
  lines_t           lines_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [7:0]       rsp_data_q;
  logic             busy_q;

  // Phase counter preload: timed states last exactly T_x cycles.
  function automatic logic [CNT_W-1:0] phase_load(input state_t st);
    case (st)
      ST_SETUP:     return CNT_W'(T_SETUP - 1);
      ST_PRE:       return CNT_W'(T_PRE - 1);
      ST_SENSE:     return CNT_W'(T_SENSE - 1);
      ST_PROGRAM:   return CNT_W'(T_PROG - 1);
      ST_ERASE:     return CNT_W'(T_ERASE - 1);
      ST_DISCHARGE: return CNT_W'(T_DIS - 1);
      default:      return '0;
    endcase
  endfunction

  // Array biasing for a state; the non-addressed block's wordlines stay low.
  function automatic lines_t lines_for(input state_t st, input logic [1:0] op,
                                       input logic [2:0] addr, input logic [7:0] wdata);
    lines_t     l;
    logic [1:0] blk_sel;
    logic [3:0] wl_sel;
    logic [3:0] wl_bias;
    l       = '0;
    blk_sel = addr[2] ? 2'b10 : 2'b01;
    wl_sel  = 4'b0001 << addr[1:0];
    wl_bias = '0;
    case (st)
      ST_SETUP: begin
        l.ssl = (op == OP_READ || op == OP_PROG) ? blk_sel : 2'b00;
        l.gsl = (op == OP_READ) ? blk_sel : 2'b00;
      end
      ST_PRE: begin
        l.ssl   = blk_sel;
        l.gsl   = blk_sel;
        wl_bias = ~wl_sel;
        l.sen1  = 1'b1;
      end
      ST_SENSE: begin
        l.ssl   = blk_sel;
        l.gsl   = blk_sel;
        wl_bias = ~wl_sel;
        l.sen2  = 1'b1;
      end
      ST_CAPTURE: begin
        l.ssl    = blk_sel;
        l.gsl    = blk_sel;
        wl_bias  = ~wl_sel;
        l.sen2   = 1'b1;
        l.out_en = wl_sel;
      end
      ST_PROGRAM: begin
        l.ssl    = blk_sel;
        wl_bias  = 4'hF;
        l.bl_oe  = 1'b1;
        l.bl_out = ~wdata;
      end
      ST_ERASE: begin
        l.sl   = 1'b1;
        l.psub = 1'b1;
      end
      default: ;
    endcase
    if (addr[2]) l.wl1 = wl_bias;
    else         l.wl0 = wl_bias;
    return l;
  endfunction

  // Successor of the current timed state once its counter expires.
  always_comb begin
    succ = ST_DONE;
    case (state_q)
      ST_SETUP: begin
        case (op_q)
          OP_READ: succ = ST_PRE;
          OP_PROG: succ = ST_PROGRAM;
          default: succ = ST_ERASE;
        endcase
      end
      ST_PRE:                             succ = ST_SENSE;
      ST_SENSE:                           succ = ST_CAPTURE;
      ST_CAPTURE, ST_PROGRAM, ST_ERASE:   succ = ST_DISCHARGE;
      default:                            succ = ST_DONE;
    endcase
  end

  // Sequencer: command accept, phase timing, response hold.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lines_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_op == OP_RSV) begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state_q <= ST_SETUP;
              cnt_q   <= phase_load(ST_SETUP);
              lines_q <= lines_for(ST_SETUP, cmd_op, cmd_addr, cmd_wdata);
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= succ;
            cnt_q   <= phase_load(succ);
            lines_q <= lines_for(succ, op_q, addr_q, wdata_q);
            if (state_q == ST_CAPTURE) rsp_data_q  <= sa_out;
            if (succ == ST_PROGRAM)    rsp_data_q  <= wdata_q;
            if (succ == ST_ERASE)      rsp_data_q  <= 8'hFF;
            if (succ == ST_DONE)       rsp_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign SSL       = lines_q.ssl;
  assign GSL       = lines_q.gsl;
  assign WL0       = lines_q.wl0;
  assign WL1       = lines_q.wl1;
  assign SL        = lines_q.sl;
  assign PSUB      = lines_q.psub;
  assign sen1      = lines_q.sen1;
  assign sen2      = lines_q.sen2;
  assign out_en    = lines_q.out_en;
  assign bl_out    = lines_q.bl_out;
  assign bl_oe     = lines_q.bl_oe;

endmodule
